// File: rtl/gw_lcd_pkg.sv
// gw_lcd_pkg: shared types and constants for the LCD segment scanner.
//   lcd_scan_state_t : scanner FSM encoding
//   lcd_frame_t      : one complete 128-bit segment frame
//   frame_idx()      : bit position of a segment inside a frame,
//                      laid out as {h[1:0], b_not_a, seg[3:0]}
package gw_lcd_pkg;

    localparam int unsigned H_COUNT      = 4;
    localparam int unsigned SEGS_PER_BUS = 16;
    localparam int unsigned FRAME_BITS   = 128;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        PUBLISH
    } lcd_scan_state_t;

    typedef logic [FRAME_BITS-1:0] lcd_frame_t;

    function automatic logic [6:0] frame_idx(
        input logic [1:0] h,
        input logic       b,
        input logic [3:0] seg
    );
        return {h, b, seg};
    endfunction

endpackage

// File: rtl/lcd_frame_slot.sv
// lcd_frame_slot: holds the published segment frame and runs the
// valid/ready handshake towards the video renderer.
//   clk, reset_n : clock, asynchronous active-low reset
//   publish      : one-cycle request to publish next_frame
//   next_frame   : frame offered by the scanner
//   frame_ready  : renderer accepts the current frame
//   frame        : published frame (stable while frame_valid=1)
//   frame_valid  : frame holds an unconsumed frame
//   overrun      : sticky, a publish was dropped because the slot was full
module lcd_frame_slot
    import gw_lcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       publish,
    input  lcd_frame_t next_frame,
    input  logic       frame_ready,
    output lcd_frame_t frame,
    output logic       frame_valid,
    output logic       overrun
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame       <= '0;
            frame_valid <= 1'b0;
            overrun     <= 1'b0;
        end else if (publish) begin
            // An accept in the publish cycle frees the slot for the new frame.
            if (!frame_valid || frame_ready) begin
                frame       <= next_frame;
                frame_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (frame_valid && frame_ready) begin
            frame_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lcd_scanner.sv
// lcd_scanner: reading end of the display-RAM segment cache. Steps the LCD
// H select through 0..3, samples the A/B segment buses once per H after a
// settle delay, and publishes each complete 128-bit frame to the renderer.
//   clk, reset_n           : clock, asynchronous active-low reset
//   enable                 : scanning enabled (stops at the next H boundary)
//   lcd_h                  : H select to the segment cache
//   segment_a, segment_b   : segment buses for the current lcd_h
//   frame, frame_valid     : published frame and its valid flag
//   frame_ready            : renderer accepts the frame
//   overrun                : sticky, a completed frame was dropped
//   scanning               : FSM is not idle
// Parameters: SCAN_DIV (cycles per H, 4..65535), SETTLE (1..SCAN_DIV-1).
// Optional: define LCD_SCANNER_PERSIST_EN to OR each published frame with
// the shadow of the previous completed frame (LCD persistence emulation).
module lcd_scanner #(
    parameter int unsigned SCAN_DIV = 1024,
    parameter int unsigned SETTLE   = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         enable,
    output logic [1:0]   lcd_h,
    input  logic [15:0]  segment_a,
    input  logic [15:0]  segment_b,
    output logic [127:0] frame,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic         overrun,
    output logic         scanning
);
    import gw_lcd_pkg::*;

    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    localparam logic [15:0] SAMPLE_AT   = 16'(SETTLE);
    localparam logic [15:0] DWELL_LAST  = 16'(SCAN_DIV - 1);

    lcd_scan_state_t state, state_next;
    logic [15:0]     count, count_next;
    logic [1:0]      h_next;
    logic            capture;
    logic            publish;
    lcd_frame_t      shadow;
    lcd_frame_t      publish_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            count <= '0;
            lcd_h <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
            lcd_h <= h_next;
        end
    end

    // The post-sample dwell stays in SAMPLE; the capture happens only on its
    // first cycle (count==SETTLE), so the counter runs unbroken across the
    // whole H period and every period is exactly SCAN_DIV cycles.
    always_comb begin
        state_next = state;
        count_next = count;
        h_next     = lcd_h;
        capture    = 1'b0;
        publish    = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = gw_lcd_pkg::SETTLE;
                    h_next     = '0;
                    count_next = '0;
                end
            end
            gw_lcd_pkg::SETTLE: begin
                count_next = count + 16'd1;
                if (count == SETTLE_LAST) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                capture = (count == SAMPLE_AT);
                if (count == DWELL_LAST) begin
                    if (lcd_h == 2'd3) begin
                        state_next = PUBLISH;
                    end else if (!enable) begin
                        // Partial frame abandoned; lcd_h held until re-enable.
                        state_next = IDLE;
                        count_next = '0;
                    end else begin
                        h_next     = lcd_h + 2'd1;
                        count_next = '0;
                        state_next = gw_lcd_pkg::SETTLE;
                    end
                end else begin
                    count_next = count + 16'd1;
                end
            end
            PUBLISH: begin
                publish    = 1'b1;
                h_next     = '0;
                count_next = '0;
                state_next = enable ? gw_lcd_pkg::SETTLE : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (capture) begin
            shadow[frame_idx(lcd_h, 1'b0, 4'd0) +: 32] <= {segment_b, segment_a};
        end
    end

`ifdef LCD_SCANNER_PERSIST_EN
    lcd_frame_t prev_shadow;

    // Updated on every publish, including ones the slot drops.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_shadow <= '0;
        end else if (publish) begin
            prev_shadow <= shadow;
        end
    end

    assign publish_data = shadow | prev_shadow;
`else
    assign publish_data = shadow;
`endif

    lcd_frame_slot u_slot (
        .clk         (clk),
        .reset_n     (reset_n),
        .publish     (publish),
        .next_frame  (publish_data),
        .frame_ready (frame_ready),
        .frame       (frame),
        .frame_valid (frame_valid),
        .overrun     (overrun)
    );

    assign scanning = (state != IDLE);

endmodule

// File: tb/tb_lcd_scanner.sv
// tb_lcd_scanner: directed self-checking bench for lcd_scanner with
// SCAN_DIV=8, SETTLE=2. Cycle k counts rising edges after reset release;
// with enable raised at k=0 a frame publishes at k=33*m and is visible
// on frame/frame_valid from k=33*m+1.
module tb_lcd_scanner;

    localparam int unsigned SCAN_DIV = 8;
    localparam int unsigned SETTLE   = 2;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         enable;
    logic [1:0]   lcd_h;
    logic [15:0]  segment_a;
    logic [15:0]  segment_b;
    logic [127:0] frame;
    logic         frame_valid;
    logic         frame_ready;
    logic         overrun;
    logic         scanning;

    int unsigned  mode;
    logic [15:0]  base_a;
    logic [15:0]  base_b;
    int           checks = 0;
    int           errors = 0;
    int           k = 0;

    always #5 clk = ~clk;

    // Segment cache model: 0 = base|h, 1 = only A bit 5 at H=0, else zero.
    always_comb begin
        segment_a = '0;
        segment_b = '0;
        case (mode)
            0: begin
                segment_a = base_a | {14'b0, lcd_h};
                segment_b = base_b | {14'b0, lcd_h};
            end
            1: begin
                segment_a = (lcd_h == 2'd0) ? 16'h0020 : 16'h0000;
            end
            default: begin
                segment_a = '0;
                segment_b = '0;
            end
        endcase
    end

    lcd_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .SETTLE   (SETTLE)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .lcd_h       (lcd_h),
        .segment_a   (segment_a),
        .segment_b   (segment_b),
        .frame       (frame),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun),
        .scanning    (scanning)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    function automatic logic [127:0] make_frame(input logic [15:0] a, input logic [15:0] b);
        logic [127:0] f;
        f = '0;
        for (int h = 0; h < 4; h++) begin
            f[h*32 +: 32] = {b | 16'(h), a | 16'(h)};
        end
        return f;
    endfunction

    task automatic go_to(input int t);
        while (k < t) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    task automatic reset_dut();
        reset_n     = 1'b0;
        enable      = 1'b0;
        frame_ready = 1'b0;
        mode        = 0;
        base_a      = 16'h1000;
        base_b      = 16'hB000;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        k = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [127:0] f1;

        // Reset values and IDLE hold with enable low
        reset_dut();
        check("rst_lcd_h", lcd_h, 0);
        check("rst_frame", frame, 0);
        check("rst_valid", frame_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_scanning", scanning, 0);
        go_to(5);
        check("idle_hold_scanning", scanning, 0);
        check("idle_hold_valid", frame_valid, 0);

        // Basic frame
        reset_dut();
        enable      = 1'b1;
        frame_ready = 1'b1;
        for (int t = 1; t <= 32; t++) begin
            go_to(t);
            check("basic_lcd_h_seq", lcd_h, 128'((t - 1) / 8));
        end
        check("basic_scanning", scanning, 1);
        go_to(33);
        check("basic_valid_pre", frame_valid, 0);
        go_to(34);
        check("basic_valid", frame_valid, 1);
        check("basic_frame", frame, make_frame(16'h1000, 16'hB000));
        check("basic_lcd_h_wrap", lcd_h, 0);
        go_to(35);
        check("basic_valid_consumed", frame_valid, 0);
        check("basic_frame_kept", frame, make_frame(16'h1000, 16'hB000));

        // Backpressure
        reset_dut();
        enable = 1'b1;
        f1 = make_frame(16'h1000, 16'hB000);
        go_to(34);
        check("bp_f1_valid", frame_valid, 1);
        check("bp_f1_frame", frame, f1);
        base_a = 16'h2000;
        go_to(66);
        check("bp_overrun_pre", overrun, 0);
        go_to(67);
        check("bp_overrun_set", overrun, 1);
        check("bp_f1_retained", frame, f1);
        base_a = 16'h3000;
        go_to(100);
        check("bp_f1_retained3", frame, f1);
        check("bp_valid_held", frame_valid, 1);
        frame_ready = 1'b1;
        base_a = 16'h4000;
        go_to(101);
        check("bp_valid_drop", frame_valid, 0);
        go_to(133);
        check("bp_fresh_valid", frame_valid, 1);
        check("bp_fresh_frame", frame, make_frame(16'h4000, 16'hB000));
        check("bp_overrun_sticky", overrun, 1);

        // Same-cycle accept + publish
        reset_dut();
        enable = 1'b1;
        go_to(34);
        check("sc_f1_valid", frame_valid, 1);
        base_a = 16'h5000;
        go_to(66);
        check("sc_pre_frame", frame, make_frame(16'h1000, 16'hB000));
        frame_ready = 1'b1;
        go_to(67);
        frame_ready = 1'b0;
        check("sc_valid", frame_valid, 1);
        check("sc_frame", frame, make_frame(16'h5000, 16'hB000));
        check("sc_overrun", overrun, 0);

        // Enable dropped during H=2
        reset_dut();
        enable      = 1'b1;
        frame_ready = 1'b1;
        go_to(18);
        enable = 1'b0;
        go_to(24);
        check("en_dwell_scanning", scanning, 1);
        check("en_dwell_lcd_h", lcd_h, 2);
        go_to(25);
        check("en_idle_scanning", scanning, 0);
        check("en_idle_lcd_h", lcd_h, 2);
        check("en_idle_valid", frame_valid, 0);
        go_to(30);
        check("en_idle_hold", scanning, 0);
        base_a = 16'h7000;
        base_b = 16'hC000;
        enable = 1'b1;
        go_to(31);
        check("en_restart_lcd_h", lcd_h, 0);
        check("en_restart_scanning", scanning, 1);
        go_to(63);
        check("en_valid_pre", frame_valid, 0);
        go_to(64);
        check("en_valid", frame_valid, 1);
        check("en_frame", frame, make_frame(16'h7000, 16'hC000));

        // Asynchronous reset in the middle of an H=1 SAMPLE cycle
        reset_dut();
        enable = 1'b1;
        go_to(77);
        check("ar_pre_valid", frame_valid, 1);
        check("ar_pre_overrun", overrun, 1);
        check("ar_pre_lcd_h", lcd_h, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("ar_lcd_h", lcd_h, 0);
        check("ar_frame", frame, 0);
        check("ar_valid", frame_valid, 0);
        check("ar_overrun", overrun, 0);
        check("ar_scanning", scanning, 0);
        #9;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("ar_rescan", scanning, 1);
        check("ar_rescan_lcd_h", lcd_h, 0);
        check("ar_rescan_valid", frame_valid, 0);

        // Persistence
        reset_dut();
        enable      = 1'b1;
        frame_ready = 1'b1;
        mode        = 1;
        go_to(34);
        check("ps_f1", frame, 128'h20);
        mode = 2;
        go_to(67);
        check("ps_f2_valid", frame_valid, 1);
`ifdef LCD_SCANNER_PERSIST_EN
        check("ps_f2", frame, 128'h20);
`else
        check("ps_f2", frame, 128'h0);
`endif
        go_to(100);
        check("ps_f3_valid", frame_valid, 1);
        check("ps_f3", frame, 128'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
